// File: rtl/counter_sum_pkg.sv
// counter_sum_pkg: shared widths, FIFO entry layout and collector states
package counter_sum_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 8;

    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] w;
    } sum_entry_t;

    typedef enum logic {RUN, FLUSH} coll_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with one-cycle clear; head reads zero when empty
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? T'(0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/counter_sum_collector.sv
// counter_sum_collector: checks W against a+b, buffers results and keeps saturating statistics
module counter_sum_collector
    import counter_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [DATA_W-1:0]      in_b,
    input  logic [DATA_W-1:0]      in_w,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_w,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [ACC_W-1:0]       acc_total,
    output logic                   acc_sat,
    output logic [ACC_W-1:0]       sample_cnt,
    output logic [ACC_W-1:0]       err_cnt
);
    coll_state_t       state, state_next;
    sum_entry_t        entry, head;
    logic              full, empty, accept, pop, err;
    logic [DATA_W-1:0] sum_ab;
    logic [ACC_W:0]    acc_sum;

    assign in_ready  = (state == RUN) && !full;
    assign out_valid = (state == RUN) && !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign sum_ab    = in_a + in_b;
    assign err       = in_w != sum_ab;
    assign entry     = '{err: err, w: in_w};
    assign out_w     = head.w;
    assign out_err   = head.err;
    assign acc_sum   = {1'b0, acc_total} + (ACC_W+1)'(in_w);

    sync_fifo #(.T(sum_entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (state == FLUSH),
        .push  (accept),
        .pop   (pop),
        .din   (entry),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_next = (state == FLUSH) ? RUN : (flush ? FLUSH : RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // statistics move only on accepted samples; each counter clamps at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_total  <= '0;
            acc_sat    <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (accept) begin
            acc_total  <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            acc_sat    <= acc_sat || acc_sum[ACC_W];
            sample_cnt <= sample_cnt + ACC_W'(sample_cnt != '1);
            err_cnt    <= err_cnt + ACC_W'(err && (err_cnt != '1));
        end
    end
endmodule

// File: tb/tb_counter_sum_collector.sv
// tb_counter_sum_collector: directed vectors with hand-computed expectations
module tb_counter_sum_collector;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, flush, out_valid, out_ready, out_err, acc_sat;
    logic [3:0] in_a, in_b, in_w, out_w;
    logic [2:0] fifo_count;
    logic [7:0] acc_total, sample_cnt, err_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    counter_sum_collector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_err(out_err),
        .fifo_count(fifo_count), .acc_total(acc_total), .acc_sat(acc_sat),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input int w);
        in_valid = 1'b1;
        in_a = 4'(a);
        in_b = 4'(b);
        in_w = 4'(w);
    endtask

    task automatic send(input int a, input int b, input int w);
        drive(a, b, w);
        chk("send_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ovalid"}, int'(out_valid), 0);
        chk({tag, "_iready"}, int'(in_ready), 1);
        chk({tag, "_ow"}, int'(out_w), 0);
        chk({tag, "_oerr"}, int'(out_err), 0);
        chk({tag, "_cnt"}, int'(fifo_count), 0);
        chk({tag, "_acc"}, int'(acc_total), 0);
        chk({tag, "_sat"}, int'(acc_sat), 0);
        chk({tag, "_smp"}, int'(sample_cnt), 0);
        chk({tag, "_errc"}, int'(err_cnt), 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_w = '0;
        step(); step();
        reset = 1'b0;
        chk_reset_state("rst");

        // basic accept and one-cycle latency
        send(2, 3, 5);
        chk("t1_ovalid", int'(out_valid), 1);
        chk("t1_ow", int'(out_w), 5);
        chk("t1_oerr", int'(out_err), 0);
        chk("t1_smp", int'(sample_cnt), 1);
        chk("t1_acc", int'(acc_total), 5);
        chk("t1_errc", int'(err_cnt), 0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_drain", int'(fifo_count), 0);

        // mismatch, then legal wrap-around
        send(2, 3, 6);
        chk("t2_oerr", int'(out_err), 1);
        chk("t2_errc", int'(err_cnt), 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        send(9, 9, 2);
        chk("t2_wrap_oerr", int'(out_err), 0);
        chk("t2_wrap_ow", int'(out_w), 2);
        chk("t2_wrap_errc", int'(err_cnt), 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // fill to full with sink stalled, then drain in order
        for (int i = 1; i <= 4; i++) send(i, 0, i);
        chk("t3_full_cnt", int'(fifo_count), 4);
        chk("t3_full_irdy", int'(in_ready), 0);
        drive(5, 0, 5);
        step();
        chk("t3_held_cnt", int'(fifo_count), 4);
        chk("t3_held_irdy", int'(in_ready), 0);
        out_ready = 1'b1;
        chk("t3_pop1", int'(out_w), 1);
        step();
        chk("t3_cnt_a", int'(fifo_count), 3);
        chk("t3_irdy_a", int'(in_ready), 1);
        chk("t3_pop2", int'(out_w), 2);
        step();
        in_valid = 1'b0;
        chk("t3_cnt_b", int'(fifo_count), 3);
        for (int i = 3; i <= 5; i++) begin
            chk("t3_pop", int'(out_w), i);
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", int'(fifo_count), 0);
        chk("t3_smp", int'(sample_cnt), 8);
        chk("t3_acc", int'(acc_total), 28);

        // simultaneous push/pop at count 2 across pointer wrap
        send(10, 0, 10);
        send(11, 0, 11);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(12 + i, 0, 12 + i);
            chk("t4_head", int'(out_w), 10 + i);
            step();
            chk("t4_cnt", int'(fifo_count), 2);
        end
        in_valid = 1'b0;
        chk("t4_tail0", int'(out_w), 13);
        step();
        chk("t4_tail1", int'(out_w), 14);
        step();
        out_ready = 1'b0;
        chk("t4_empty", int'(fifo_count), 0);
        chk("t4_acc", int'(acc_total), 88);

        // accumulator saturation from a clean start
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b1;
        drive(15, 0, 15);
        for (int i = 0; i < 17; i++) step();
        chk("t5_acc17", int'(acc_total), 255);
        chk("t5_sat17", int'(acc_sat), 0);
        step();
        in_valid = 1'b0;
        chk("t5_acc18", int'(acc_total), 255);
        chk("t5_sat18", int'(acc_sat), 1);
        chk("t5_smp18", int'(sample_cnt), 18);
        step();
        out_ready = 1'b0;
        chk("t5_sat_hold", int'(acc_sat), 1);
        chk("t5_empty", int'(fifo_count), 0);

        // flush with three buffered entries; input offered during FLUSH is refused
        for (int i = 1; i <= 3; i++) send(i, 0, i);
        chk("t6_cnt", int'(fifo_count), 3);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t6_fl_ovalid", int'(out_valid), 0);
        chk("t6_fl_irdy", int'(in_ready), 0);
        drive(1, 1, 2);
        step();
        in_valid = 1'b0;
        chk("t6_cnt0", int'(fifo_count), 0);
        chk("t6_ovalid", int'(out_valid), 0);
        chk("t6_irdy", int'(in_ready), 1);
        chk("t6_smp", int'(sample_cnt), 21);
        chk("t6_acc", int'(acc_total), 255);
        chk("t6_sat", int'(acc_sat), 1);

        // flush on an empty FIFO still costs one cycle
        flush = 1'b1; step(); flush = 1'b0;
        chk("t7_fl_irdy", int'(in_ready), 0);
        step();
        chk("t7_irdy", int'(in_ready), 1);

        // reset with two entries buffered
        send(1, 1, 2);
        send(2, 2, 4);
        chk("t8_cnt", int'(fifo_count), 2);
        reset = 1'b1; step(); reset = 1'b0;
        chk_reset_state("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
